// File: rtl/md_sched.sv
// rtl/md_sched.sv - HI/LO owner: fixed-latency multiply/divide scheduler with D-stage stall request
// MULT/DIV results are computed at issue, held in p_hi/p_lo, and committed after the configured latency.
module md_sched #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        issue_ok;
  logic [63:0] mul_s, mul_u;
  logic [31:0] div_q_s, div_r_s, div_q_u, div_r_u;
  logic signed [31:0] a_s, b_s;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_u = {32'd0, a} * {32'd0, b};

  // Zero divisor and INT_MIN/-1 are pinned explicitly rather than left to the divider.
  always_comb begin
    div_q_s = 32'hFFFF_FFFF;
    div_r_s = a;
    div_q_u = 32'hFFFF_FFFF;
    div_r_u = a;
    if (b != 32'd0) begin
      div_q_u = a / b;
      div_r_u = a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        div_q_s = 32'h8000_0000;
        div_r_s = 32'd0;
      end else begin
        div_q_s = a_s / b_s;
        div_r_s = a_s % b_s;
      end
    end
  end

  assign busy     = (state_q == S_RUN);
  assign issue_ok = start & ~flush & ~busy & (op <= 3'd5);
  assign stall_md = md_use_D & (busy | (start & ~flush & (op <= 3'd3)));
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_RUN) begin
      if (cnt_q == 4'd1) begin
        hi_d    = p_hi_q;
        lo_d    = p_lo_q;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (issue_ok) begin
      case (op)
        3'd0: begin
          {p_hi_d, p_lo_d} = mul_s;
          cnt_d   = 4'(MUL_CYCLES);
          state_d = S_RUN;
        end
        3'd1: begin
          {p_hi_d, p_lo_d} = mul_u;
          cnt_d   = 4'(MUL_CYCLES);
          state_d = S_RUN;
        end
        3'd2: begin
          p_lo_d  = div_q_s;
          p_hi_d  = div_r_s;
          cnt_d   = 4'(DIV_CYCLES);
          state_d = S_RUN;
        end
        3'd3: begin
          p_lo_d  = div_q_u;
          p_hi_d  = div_r_u;
          cnt_d   = 4'(DIV_CYCLES);
          state_d = S_RUN;
        end
        3'd4:    hi_d = a;
        3'd5:    lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed bench for md_sched with hand-computed HI/LO, busy and stall counts
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, then count busy and stall cycles until busy drops.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic use_d, input int eb, input int es,
                       input logic [31:0] eh, input logic [31:0] el);
    int nb;
    int ns;
    op = o; a = x; b = y; md_use_D = use_d; start = 1'b1;
    #1;
    ns = stall_md ? 1 : 0;
    nb = 0;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      if (stall_md) ns++;
      @(posedge clk); #2;
    end
    chk({tag, "_busy"}, nb, eb);
    chk({tag, "_stall"}, ns, es);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    md_use_D = 1'b0;
  endtask

  initial begin
    int nb;
    reset = 1'b0; start = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; md_use_D = 1'b1;
    #3;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall_comb", {31'd0, stall_md}, 32'd1);
    start = 1'b0; md_use_D = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    do_op("mult",     3'd0, 32'hFFFF_FFFE, 32'd3,         1'b0, 5,  0,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("divu",     3'd3, 32'd100,       32'd7,         1'b1, 10, 11, 32'd2,         32'd14);
    do_op("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 10, 0,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_z",    3'd2, 32'd5,         32'd0,         1'b0, 10, 0,  32'd5,         32'hFFFF_FFFF);
    do_op("divu_z",   3'd3, 32'd9,         32'd0,         1'b0, 10, 0,  32'd9,         32'hFFFF_FFFF);
    do_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 0,  32'd0,         32'h8000_0000);
    do_op("multu",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  6,  32'hFFFF_FFFE, 32'd1);
    do_op("mtlo",     3'd5, 32'h1234_5678, 32'd0,         1'b1, 0,  0,  32'hFFFF_FFFE, 32'h1234_5678);
    do_op("mthi",     3'd4, 32'hCAFE_F00D, 32'd0,         1'b0, 0,  0,  32'hCAFE_F00D, 32'h1234_5678);
    do_op("div_negb", 3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 10, 0,  32'd1,         32'hFFFF_FFFD);
    do_op("nop6",     3'd6, 32'h5555_5555, 32'd1,         1'b1, 0,  0,  32'd1,         32'hFFFF_FFFD);

    op = 3'd2; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1; md_use_D = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_md}, 32'd0);
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0; md_use_D = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'd1);
    chk("flush_lo", lo, 32'hFFFF_FFFD);

    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    op = 3'd1; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    nb = 2;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      @(posedge clk); #2;
    end
    chk("busy_ign_busy", nb, 10);
    chk("busy_ign_hi", hi, 32'd2);
    chk("busy_ign_lo", lo, 32'd14);
    @(posedge clk); #2;
    chk("busy_ign_noqueue", {31'd0, busy}, 32'd0);

    op = 3'd0; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rrun_busy", {31'd0, busy}, 32'd0);
    chk("rrun_hi", hi, 32'd0);
    chk("rrun_lo", lo, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (8) begin
      @(posedge clk); #2;
    end
    chk("rrun_late_busy", {31'd0, busy}, 32'd0);
    chk("rrun_late_hi", hi, 32'd0);
    chk("rrun_late_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
